// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver: SOF, LEN, payload, XOR checksum.
// Good payloads are buffered and replayed over ready/valid; errors are one-cycle pulses.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | hunting for SOF, other bytes ignored
// S_LEN     | expecting length byte
// S_PAYLOAD | storing payload bytes into the buffer
// S_CHK     | expecting checksum byte
// S_SEND    | streaming buffered payload, incoming bytes dropped
module uart_frame_parser #(
   parameter int         MAX_LEN     = 16,
   parameter int         TIMEOUT_CYC = 1000,
   parameter logic [7:0] SOF         = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       err_chk,
   output logic       err_len,
   output logic       err_timeout,
   output logic       overrun
);

   localparam int IW = $clog2(MAX_LEN + 1);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
      S_CHK,
      S_SEND
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   len, len_nxt;
   logic [IW-1:0]   wr_idx, wr_idx_nxt;
   logic [IW-1:0]   rd_idx, rd_idx_nxt;
   logic [7:0]      chk, chk_nxt;
   logic [TW-1:0]   tmo_cnt, tmo_cnt_nxt;
   logic            err_chk_nxt, err_len_nxt, err_timeout_nxt, overrun_nxt;
   logic            timed, tmo_hit, buf_we;
   logic [7:0]      buffer [0:MAX_LEN-1];

   assign timed   = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
   assign tmo_hit = timed && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
   assign buf_we  = (state == S_PAYLOAD) && rx_valid;

   assign out_valid = (state == S_SEND);
   assign out_last  = (state == S_SEND) && (rd_idx == len - IW'(1));
   assign out_data  = (state == S_SEND) ? buffer[rd_idx[AW-1:0]] : 8'h00;

   always_comb begin
      state_nxt       = state;
      len_nxt         = len;
      wr_idx_nxt      = wr_idx;
      rd_idx_nxt      = rd_idx;
      chk_nxt         = chk;
      err_chk_nxt     = 1'b0;
      err_len_nxt     = 1'b0;
      err_timeout_nxt = 1'b0;
      overrun_nxt     = 1'b0;
      tmo_cnt_nxt     = '0;

      // counter only runs while a frame is being received; any byte restarts it
      if (timed && !rx_valid && !tmo_hit) tmo_cnt_nxt = tmo_cnt + TW'(1);

      case (state)
         S_IDLE: begin
            if (rx_valid && rx_data == SOF) state_nxt = S_LEN;
         end
         S_LEN: begin
            if (rx_valid) begin
               if (rx_data == 8'h00 || int'(rx_data) > MAX_LEN) begin
                  err_len_nxt = 1'b1;
                  state_nxt   = S_IDLE;
               end else begin
                  len_nxt    = IW'(rx_data);
                  chk_nxt    = rx_data;
                  wr_idx_nxt = '0;
                  state_nxt  = S_PAYLOAD;
               end
            end else if (tmo_hit) begin
               err_timeout_nxt = 1'b1;
               state_nxt       = S_IDLE;
            end
         end
         S_PAYLOAD: begin
            if (rx_valid) begin
               chk_nxt    = chk ^ rx_data;
               wr_idx_nxt = wr_idx + IW'(1);
               if (wr_idx + IW'(1) == len) state_nxt = S_CHK;
            end else if (tmo_hit) begin
               err_timeout_nxt = 1'b1;
               state_nxt       = S_IDLE;
            end
         end
         S_CHK: begin
            if (rx_valid) begin
               if (rx_data == chk) begin
                  rd_idx_nxt = '0;
                  state_nxt  = S_SEND;
               end else begin
                  err_chk_nxt = 1'b1;
                  state_nxt   = S_IDLE;
               end
            end else if (tmo_hit) begin
               err_timeout_nxt = 1'b1;
               state_nxt       = S_IDLE;
            end
         end
         S_SEND: begin
            if (rx_valid) overrun_nxt = 1'b1;
            if (out_ready) begin
               if (rd_idx == len - IW'(1)) state_nxt = S_IDLE;
               else                        rd_idx_nxt = rd_idx + IW'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         len         <= '0;
         wr_idx      <= '0;
         rd_idx      <= '0;
         chk         <= '0;
         tmo_cnt     <= '0;
         err_chk     <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_nxt;
         len         <= len_nxt;
         wr_idx      <= wr_idx_nxt;
         rd_idx      <= rd_idx_nxt;
         chk         <= chk_nxt;
         tmo_cnt     <= tmo_cnt_nxt;
         err_chk     <= err_chk_nxt;
         err_len     <= err_len_nxt;
         err_timeout <= err_timeout_nxt;
         overrun     <= overrun_nxt;
      end
   end

   // payload storage has no reset; it is only read back inside a verified frame
   always_ff @(posedge clk) begin
      if (buf_we) buffer[wr_idx[AW-1:0]] <= rx_data;
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good/bad frames, length errors,
// timeout boundary, backpressure with overrun, noise and reset aborts.
module tb_uart_frame_parser;

   localparam int TIMEOUT_CYC = 1000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_valid, out_last, err_chk, err_len, err_timeout, overrun;

   int n_assert = 0;
   int n_fail = 0;
   int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
   logic [8:0] got_q[$];

   uart_frame_parser #(.MAX_LEN(16), .TIMEOUT_CYC(TIMEOUT_CYC), .SOF(8'hA5)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .err_chk(err_chk), .err_len(err_len),
      .err_timeout(err_timeout), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // inputs change #1 after posedge, so negedge sees exactly what the next posedge uses
   always @(negedge clk) begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (err_chk)     n_chk++;
      if (err_len)     n_len++;
      if (err_timeout) n_tmo++;
      if (overrun)     n_ovr++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic clear_obs();
      got_q.delete();
      n_chk = 0; n_len = 0; n_tmo = 0; n_ovr = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) tick();
      n_assert++;
      if ({out_valid, out_last, out_data, err_chk, err_len, err_timeout, overrun} !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_outputs got v=%b l=%b d=%h ec=%b el=%b et=%b ov=%b required all 0",
                  out_valid, out_last, out_data, err_chk, err_len, err_timeout, overrun);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_good_frame();
      logic [9:0] exp_seq [4];
      exp_seq = '{{2'b10, 8'h11}, {2'b10, 8'h22}, {2'b11, 8'h33}, {2'b00, 8'h00}};
      clear_obs();
      out_ready = 1'b1;
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if ({out_valid, out_last, out_data} !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL good_cycle%0d got v/l/d=%b%b/%h required %b%b/%h", i,
                     out_valid, out_last, out_data, exp_seq[i][9], exp_seq[i][8], exp_seq[i][7:0]);
         end
         tick();
      end
      n_assert++;
      if (got_q.size() != 3 || n_chk + n_len + n_tmo + n_ovr != 0) begin
         n_fail++;
         $display("FAIL good_totals got bytes=%0d errs=%0d required bytes=3 errs=0",
                  got_q.size(), n_chk + n_len + n_tmo + n_ovr);
      end
   endtask

   task automatic test_bad_checksum();
      logic [8:0] exp_q[$];
      clear_obs();
      out_ready = 1'b1;
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h04);
      n_assert++;
      if (out_valid !== 1'b0 || err_chk !== 1'b1) begin
         n_fail++;
         $display("FAIL badchk_pulse got v=%b err_chk=%b required v=0 err_chk=1", out_valid, err_chk);
      end
      tick();
      // 02 ^ AA ^ BB = 13
      send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h13);
      repeat (3) tick();
      exp_q = '{{1'b0, 8'hAA}, {1'b1, 8'hBB}};
      n_assert++;
      if (got_q.size() != exp_q.size() || n_chk != 1) begin
         n_fail++;
         $display("FAIL badchk_count got bytes=%0d err_chk=%0d required bytes=2 err_chk=1",
                  got_q.size(), n_chk);
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_assert++;
            if (got_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL badchk_byte%0d got %h required %h", i, got_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_length();
      clear_obs();
      out_ready = 1'b1;
      send(8'hA5); send(8'h00); tick();
      send(8'hA5); send(8'h11); tick();
      n_assert++;
      if (n_len != 2) begin
         n_fail++;
         $display("FAIL len_errors got %0d required 2", n_len);
      end
      send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
      repeat (2) tick();
      // a rejected A5 length byte must not restart a frame
      send(8'hA5); send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
      repeat (2) tick();
      n_assert++;
      if (got_q.size() != 1 || n_len != 3) begin
         n_fail++;
         $display("FAIL len_follow got bytes=%0d err_len=%0d required bytes=1 err_len=3",
                  got_q.size(), n_len);
      end else begin
         n_assert++;
         if (got_q[0] !== {1'b1, 8'h7E}) begin
            n_fail++;
            $display("FAIL len_single got %h required 17e", got_q[0]);
         end
      end
   endtask

   task automatic test_timeout();
      logic exp_t;
      clear_obs();
      out_ready = 1'b1;
      send(8'hA5); send(8'h02); send(8'h11);
      for (int i = 1; i <= TIMEOUT_CYC + 3; i++) begin
         tick();
         exp_t = (i == TIMEOUT_CYC);
         n_assert++;
         if (err_timeout !== exp_t) begin
            n_fail++;
            $display("FAIL timeout_cycle%0d got %b required %b", i, err_timeout, exp_t);
         end
      end
      send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
      repeat (2) tick();
      n_assert++;
      if (n_tmo != 1 || got_q.size() != 1) begin
         n_fail++;
         $display("FAIL timeout_after got tmo=%0d bytes=%0d required tmo=1 bytes=1", n_tmo, got_q.size());
      end
      // byte lands on the very posedge the counter would expire
      clear_obs();
      send(8'hA5); send(8'h02); send(8'h11);
      repeat (TIMEOUT_CYC - 1) tick();
      send(8'h22); send(8'h31);
      repeat (3) tick();
      n_assert++;
      if (n_tmo != 0 || got_q.size() != 2) begin
         n_fail++;
         $display("FAIL timeout_edge got tmo=%0d bytes=%0d required tmo=0 bytes=2", n_tmo, got_q.size());
      end else begin
         n_assert++;
         if (got_q[0] !== {1'b0, 8'h11} || got_q[1] !== {1'b1, 8'h22}) begin
            n_fail++;
            $display("FAIL timeout_edge_data got %h %h required 011 122", got_q[0], got_q[1]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [8:0] exp_q[$];
      clear_obs();
      out_ready = 1'b0;
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            rx_valid = 1'b1;
            rx_data  = 8'h55;
         end
         tick();
         rx_valid = 1'b0;
         n_assert++;
         if ({out_valid, out_last, out_data} !== {2'b10, 8'h11}) begin
            n_fail++;
            $display("FAIL bp_hold%0d got v/l/d=%b%b/%h required 10/11", i, out_valid, out_last, out_data);
         end
      end
      n_assert++;
      if (n_ovr != 1) begin
         n_fail++;
         $display("FAIL bp_overrun got %0d required 1", n_ovr);
      end
      out_ready = 1'b1;
      repeat (4) tick();
      exp_q = '{{1'b0, 8'h11}, {1'b0, 8'h22}, {1'b1, 8'h33}};
      n_assert++;
      if (got_q.size() != 3) begin
         n_fail++;
         $display("FAIL bp_count got %0d required 3", got_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (got_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL bp_byte%0d got %h required %h", i, got_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_obs();
      out_ready = 1'b1;
      send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h13);
      tick();
      // SOF arrives together with the final handshake and must be dropped
      n_assert++;
      if (out_last !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_last got %b required 1", out_last);
      end
      send(8'hA5);
      send(8'h01); send(8'h7E); send(8'h7F);
      repeat (2) tick();
      n_assert++;
      if (n_ovr != 1 || got_q.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_drop got ovr=%0d bytes=%0d required ovr=1 bytes=2", n_ovr, got_q.size());
      end
      // SOF in the cycle right after the last handshake is accepted
      clear_obs();
      send(8'hA5); send(8'h01); send(8'h5C); send(8'h5D);
      tick();
      send(8'hA5); send(8'h01); send(8'h6C); send(8'h6D);
      repeat (2) tick();
      n_assert++;
      if (got_q.size() != 2 || n_ovr != 0) begin
         n_fail++;
         $display("FAIL b2b_resync got bytes=%0d ovr=%0d required bytes=2 ovr=0", got_q.size(), n_ovr);
      end else begin
         n_assert++;
         if (got_q[0] !== {1'b1, 8'h5C} || got_q[1] !== {1'b1, 8'h6C}) begin
            n_fail++;
            $display("FAIL b2b_resync_data got %h %h required 15c 16c", got_q[0], got_q[1]);
         end
      end
   endtask

   task automatic test_noise_reset();
      clear_obs();
      out_ready = 1'b1;
      send(8'h00); send(8'hFF); send(8'h5A);
      send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h13);
      repeat (3) tick();
      n_assert++;
      if (got_q.size() != 2 || n_chk + n_len + n_tmo + n_ovr != 0) begin
         n_fail++;
         $display("FAIL noise_count got bytes=%0d errs=%0d required bytes=2 errs=0",
                  got_q.size(), n_chk + n_len + n_tmo + n_ovr);
      end else begin
         n_assert++;
         if (got_q[0] !== {1'b0, 8'hAA} || got_q[1] !== {1'b1, 8'hBB}) begin
            n_fail++;
            $display("FAIL noise_data got %h %h required 0aa 1bb", got_q[0], got_q[1]);
         end
      end
      clear_obs();
      send(8'hA5); send(8'h03); send(8'h11);
      reset = 1'b0;
      tick();
      n_assert++;
      if ({out_valid, out_last, out_data, err_chk, err_len, err_timeout, overrun} !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_payload got v=%b d=%h required all 0", out_valid, out_data);
      end
      reset = 1'b1;
      send(8'h22); send(8'h33); send(8'h03);
      repeat (3) tick();
      n_assert++;
      if (got_q.size() != 0 || n_chk + n_len + n_tmo + n_ovr != 0) begin
         n_fail++;
         $display("FAIL reset_residue got bytes=%0d errs=%0d required 0 0",
                  got_q.size(), n_chk + n_len + n_tmo + n_ovr);
      end
      out_ready = 1'b0;
      send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
      reset = 1'b0;
      tick();
      n_assert++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_send got v=%b d=%h required v=0 d=00", out_valid, out_data);
      end
      reset = 1'b1;
      out_ready = 1'b1;
      repeat (3) tick();
      n_assert++;
      if (got_q.size() != 0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_send_after got bytes=%0d v=%b required 0 0", got_q.size(), out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_length();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_noise_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
